// File: rtl/hello_pkg.sv
// Shared types and constants for the HELLO scroller: mode encodings,
// active-low segment patterns and the 4-bit character-code type.
package hello_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  typedef logic [3:0] char_code_t;

  // Bit 6 = g ... bit 0 = a, low lights the segment
  localparam logic [6:0] SEG_H     = 7'h09;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam char_code_t CH_H  = 4'd1;
  localparam char_code_t CH_E  = 4'd2;
  localparam char_code_t CH_L1 = 4'd3;
  localparam char_code_t CH_L2 = 4'd4;
  localparam char_code_t CH_O  = 4'd5;

  // Message index i carries code i+1; indices past the code space read as blank.
  function automatic char_code_t idx_to_code(input int idx);
    return (idx < 15) ? char_code_t'(idx + 1) : '0;
  endfunction

endpackage

// File: rtl/seg_char_rom.sv
// Character code to active-low seven-segment pattern; anything undefined is blank.
module seg_char_rom
  import hello_pkg::*;
(
  input  char_code_t  i_code,
  output logic [6:0]  o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_code)
      CH_H:         o_seg = SEG_H;
      CH_E:         o_seg = SEG_E;
      CH_L1, CH_L2: o_seg = SEG_L;
      CH_O:         o_seg = SEG_O;
      default:      o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hello_scroller.sv
// Drives NUM_DIGITS seven-segment displays with a window onto "HELLO" plus
// blank padding: static, scroll left/right on a prescaled tick or manual step, or blink.
module hello_scroller
  import hello_pkg::*;
#(
  parameter  int NUM_DIGITS = 4,
  parameter  int MSG_LEN    = 9,
  parameter  int TICK_DIV   = 25000000,
  localparam int POS_W      = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic                    step,
  output logic [7*NUM_DIGITS-1:0] HEX,
  output logic [POS_W-1:0]        pos,
  output logic                    wrap
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int SUM_W = POS_W + 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);

  logic [PRE_W-1:0]                r_presc;
  logic [POS_W-1:0]                r_pos;
  logic                            r_wrap;
  logic                            r_blink_on;
  logic [NUM_DIGITS-1:0][6:0]      r_hex;

  mode_e                           w_mode;
  logic                            w_tick;
  logic                            w_adv;
  logic [NUM_DIGITS-1:0][6:0]      w_seg;

  assign w_mode = mode_e'(mode);
  assign w_tick = en && (r_presc == PRE_LAST);
  assign w_adv  = (w_tick || step) && (w_mode == MODE_LEFT || w_mode == MODE_RIGHT);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
    end
  end

  // wrap is registered alongside pos so the pulse lines up with the wrapped value
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_pos  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (w_adv) begin
        if (w_mode == MODE_LEFT) begin
          if (r_pos == POS_LAST) begin
            r_pos  <= '0;
            r_wrap <= 1'b1;
          end else begin
            r_pos <= r_pos + POS_W'(1);
          end
        end else begin
          if (r_pos == '0) begin
            r_pos  <= POS_LAST;
            r_wrap <= 1'b1;
          end else begin
            r_pos <= r_pos - POS_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_blink_on <= 1'b1;
    end else if (w_mode != MODE_BLINK) begin
      r_blink_on <= 1'b1;
    end else if (w_tick) begin
      r_blink_on <= ~r_blink_on;
    end
  end

  // Window index per digit; pos + offset < 2*MSG_LEN so one subtract is the modulo.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    localparam int OFF = NUM_DIGITS - 1 - k;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_idx;
    char_code_t       w_code;

    assign w_sum  = {1'b0, r_pos} + SUM_W'(OFF);
    assign w_idx  = (w_sum >= SUM_W'(MSG_LEN)) ? w_sum - SUM_W'(MSG_LEN) : w_sum;
    assign w_code = idx_to_code(int'(w_idx));

    seg_char_rom u_rom (
      .i_code (w_code),
      .o_seg  (w_seg[k])
    );
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_hex <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      r_hex <= r_blink_on ? w_seg : {NUM_DIGITS{SEG_BLANK}};
    end
  end

  assign HEX  = r_hex;
  assign pos  = r_pos;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_hello_scroller.sv
// Scoreboard bench for hello_scroller (4 digits, 9-char message, tick every 4 clocks).
module tb_hello_scroller;

  localparam int ND = 4;
  localparam int ML = 9;
  localparam int TD = 4;
  localparam logic [27:0] BLANK4 = {4{7'h7F}};
  localparam logic [27:0] HELL   = {7'h09, 7'h06, 7'h47, 7'h47};
  localparam logic [27:0] ELLO   = {7'h06, 7'h47, 7'h47, 7'h40};
  localparam logic [27:0] P6     = {7'h7F, 7'h7F, 7'h7F, 7'h09};
  localparam logic [27:0] P8     = {7'h7F, 7'h09, 7'h06, 7'h47};
  localparam logic [27:0] P2     = {7'h47, 7'h47, 7'h40, 7'h7F};

  logic        Clock  = 1'b0;
  logic        Resetn = 1'b0;
  logic        en     = 1'b1;
  logic [1:0]  mode   = 2'b00;
  logic        step   = 1'b0;
  logic [27:0] HEX;
  logic [3:0]  pos;
  logic        wrap;

  hello_scroller #(.NUM_DIGITS(ND), .MSG_LEN(ML), .TICK_DIV(TD)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .en     (en),
    .mode   (mode),
    .step   (step),
    .HEX    (HEX),
    .pos    (pos),
    .wrap   (wrap)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    bit          chk_hex;
    logic [27:0] hex;
    bit          chk_pos;
    logic [3:0]  pos;
    bit          chk_wrap;
    logic        wrap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic [6:0] msg [ML] = '{7'h09, 7'h06, 7'h47, 7'h47, 7'h40, 7'h7F, 7'h7F, 7'h7F, 7'h7F};

  // Reference state: prescaler count, window start, blink phase, registered outputs
  int          m_pre;
  int          m_pos;
  bit          m_blink;
  bit          m_wrap;
  logic [27:0] m_hex;

  function automatic logic [27:0] disp(input int p);
    logic [27:0] r;
    for (int k = 0; k < ND; k++) r[7*k +: 7] = msg[(p + ND - 1 - k) % ML];
    return r;
  endfunction

  task automatic model_reset();
    m_pre = 0; m_pos = 0; m_blink = 1'b1; m_wrap = 1'b0; m_hex = BLANK4;
  endtask

  task automatic push_model(input string nm);
    sb.push_back('{name:nm, chk_hex:1'b1, hex:m_hex, chk_pos:1'b1, pos:4'(m_pos),
                   chk_wrap:1'b1, wrap:m_wrap});
  endtask

  task automatic expect_hex(input string nm, input logic [27:0] h);
    sb.push_back('{name:nm, chk_hex:1'b1, hex:h, chk_pos:1'b0, pos:4'd0, chk_wrap:1'b0, wrap:1'b0});
  endtask

  task automatic expect_pos(input string nm, input logic [3:0] p);
    sb.push_back('{name:nm, chk_hex:1'b0, hex:'0, chk_pos:1'b1, pos:p, chk_wrap:1'b0, wrap:1'b0});
  endtask

  task automatic expect_wrap(input string nm, input logic w);
    sb.push_back('{name:nm, chk_hex:1'b0, hex:'0, chk_pos:1'b0, pos:4'd0, chk_wrap:1'b1, wrap:w});
  endtask

  // One clock edge: advance the reference with the inputs seen at the edge, queue its outputs
  task automatic clk1(input string nm);
    bit tick, adv;
    @(posedge Clock);
    if (Resetn) begin
      tick   = en && (m_pre == TD - 1);
      adv    = (tick || step) && (mode == 2'b01 || mode == 2'b10);
      m_hex  = m_blink ? disp(m_pos) : BLANK4;
      m_wrap = 1'b0;
      if (adv && mode == 2'b01) begin
        if (m_pos == ML - 1) begin m_pos = 0; m_wrap = 1'b1; end
        else m_pos++;
      end else if (adv && mode == 2'b10) begin
        if (m_pos == 0) begin m_pos = ML - 1; m_wrap = 1'b1; end
        else m_pos--;
      end
      if (mode != 2'b11) m_blink = 1'b1;
      else if (tick) m_blink = !m_blink;
      if (en) m_pre = tick ? 0 : m_pre + 1;
    end
    #1;
    push_model(nm);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clock);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_hex) begin
          checks++;
          if (HEX !== e.hex) begin
            errors++;
            $display("FAIL %s HEX: got %h expected %h", e.name, HEX, e.hex);
          end
        end
        if (e.chk_pos) begin
          checks++;
          if (pos !== e.pos) begin
            errors++;
            $display("FAIL %s pos: got %0d expected %0d", e.name, pos, e.pos);
          end
        end
        if (e.chk_wrap) begin
          checks++;
          if (wrap !== e.wrap) begin
            errors++;
            $display("FAIL %s wrap: got %b expected %b", e.name, wrap, e.wrap);
          end
        end
      end
    end
  end

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: condition not reached within cycle budget", nm);
  endtask

  initial begin : stim
    int n;
    model_reset();
    #1;
    repeat (3) clk1("in_reset");
    expect_hex("reset_hex", BLANK4);
    Resetn = 1'b1;

    // 1. static
    clk1("static");
    expect_hex("first_clock_hell", HELL);
    repeat (39) clk1("static");
    expect_pos("static_pos", 4'd0);

    // 2. scroll left through a full wrap
    mode = 2'b01;
    n = 0;
    do begin
      clk1("left");
      if (m_pos == 1 && m_hex == disp(1)) expect_hex("pos1_ello", ELLO);
      if (m_pos == 6 && m_hex == disp(6)) expect_hex("pos6_pattern", P6);
      n++;
    end while (!(m_wrap && m_pos == 0) && n < 60);
    if (n >= 60) bound_fail("left_wrap");
    expect_wrap("left_wrap_pulse", 1'b1);
    clk1("left_after_wrap");
    expect_wrap("left_wrap_single", 1'b0);

    // 3. scroll right from 0
    mode = 2'b10;
    n = 0;
    do begin clk1("right"); n++; end while (!m_wrap && n < 8);
    if (n >= 8) bound_fail("right_wrap");
    expect_pos("right_pos8", 4'd8);
    expect_wrap("right_wrap_pulse", 1'b1);
    clk1("right_hex");
    expect_hex("right_hex_pos8", P8);

    // 4. manual step
    mode = 2'b01;
    n = 0;
    do begin clk1("to_zero"); n++; end while (!m_wrap && n < 8);
    if (n >= 8) bound_fail("to_zero");
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1; clk1("step_en0");
      step = 1'b0; clk1("step_idle");
    end
    expect_pos("step3_pos", 4'd3);
    en = 1'b1;
    n = 0;
    while (m_pre != TD - 1 && n < 8) begin clk1("align_tick"); n++; end
    if (n >= 8) bound_fail("align_tick");
    step = 1'b1; clk1("step_with_tick");
    step = 1'b0;
    expect_pos("step_tick_once", 4'd4);
    mode = 2'b00;
    step = 1'b1; clk1("step_static");
    step = 1'b0; clk1("static_idle");
    expect_pos("step_static_ignored", 4'd4);

    // 5. blink from pos 2
    mode = 2'b10; en = 1'b0;
    repeat (2) begin
      step = 1'b1; clk1("step_right");
      step = 1'b0; clk1("step_idle");
    end
    expect_pos("blink_start_pos", 4'd2);
    mode = 2'b00; en = 1'b1;
    n = 0;
    while (m_pre != 0 && n < 8) begin clk1("align_zero"); n++; end
    if (n >= 8) bound_fail("align_zero");
    mode = 2'b11;
    for (int j = 1; j <= 12; j++) begin
      clk1("blink");
      expect_hex("blink_phase", (j >= 5 && j <= 8) ? BLANK4 : P2);
    end
    clk1("blink_off");
    expect_hex("blink_blanked", BLANK4);
    mode = 2'b00;
    clk1("restore1");
    clk1("restore2");
    expect_hex("blink_restored", P2);
    expect_pos("blink_restored_pos", 4'd2);

    // 6. reset mid-scroll
    mode = 2'b01;
    n = 0;
    while (m_pos != 5 && n < 40) begin clk1("to_pos5"); n++; end
    if (n >= 40) bound_fail("to_pos5");
    expect_pos("mid_scroll_pos5", 4'd5);
    @(negedge Clock);
    @(posedge Clock); #1;
    Resetn = 1'b0;
    #1;
    model_reset();
    expect_hex("async_reset_hex", BLANK4);
    expect_pos("async_reset_pos", 4'd0);
    expect_wrap("async_reset_wrap", 1'b0);
    clk1("held_reset");
    Resetn = 1'b1;
    mode = 2'b00;
    clk1("after_reset");
    expect_hex("after_reset_hell", HELL);
    expect_pos("after_reset_pos", 4'd0);

    repeat (2) @(negedge Clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
